// File: rtl/if_id_buffer_pkg.sv
// Shared constants for the fetch/decode pipeline buffer: NOP encoding, occupancy states, default widths.
package if_id_buffer_pkg;

  localparam int ADDRESS_BITS_DEFAULT = 16;
  localparam int DATA_WIDTH_DEFAULT   = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Encoding doubles as the registered occupancy count
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch-side push and decode-side pop signals of the IF/ID buffer.
interface if_id_buffer_if
  import if_id_buffer_pkg::*;
#(
  parameter int ADDRESS_BITS = ADDRESS_BITS_DEFAULT,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT
);

  logic                    in_valid;
  logic                    in_ready;
  logic [ADDRESS_BITS-1:0] in_PC;
  logic [DATA_WIDTH-1:0]   in_instruction;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [ADDRESS_BITS-1:0] out_PC;
  logic [ADDRESS_BITS-1:0] out_PC_plus4;
  logic [DATA_WIDTH-1:0]   out_instruction;
  logic [1:0]              occupancy;

  modport master (
    output in_valid, in_PC, in_instruction, flush, out_ready,
    input  in_ready, out_valid, out_PC, out_PC_plus4, out_instruction, occupancy
  );

  modport slave (
    input  in_valid, in_PC, in_instruction, flush, out_ready,
    output in_ready, out_valid, out_PC, out_PC_plus4, out_instruction, occupancy
  );

endinterface

// File: rtl/if_id_buffer.sv
// Two-entry in-order IF/ID queue; a push into an empty queue is visible one cycle later.
// Ready and valid come from registered state only, so there is no out_ready -> in_ready path.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int ADDRESS_BITS = ADDRESS_BITS_DEFAULT,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  if_id_buffer_if.slave  bus
);

  state_t                  state;
  state_t                  state_nxt;
  logic                    push;
  logic                    pop;
  logic [ADDRESS_BITS-1:0] head_pc;
  logic [ADDRESS_BITS-1:0] tail_pc;
  logic [DATA_WIDTH-1:0]   head_instr;
  logic [DATA_WIDTH-1:0]   tail_instr;

  assign bus.in_ready  = reset && (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop) begin
            state_nxt = FULL;
          end else if (pop && !push) begin
            state_nxt = EMPTY;
          end
        end
        FULL:    if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Head registers are left untouched on the way to EMPTY so out_PC keeps the last head
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_pc    <= '0;
      head_instr <= DATA_WIDTH'(NOP_INSTR);
      tail_pc    <= '0;
      tail_instr <= '0;
    end else if (!bus.flush) begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_pc    <= bus.in_PC;
            head_instr <= bus.in_instruction;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_pc    <= bus.in_PC;
            head_instr <= bus.in_instruction;
          end else if (push) begin
            tail_pc    <= bus.in_PC;
            tail_instr <= bus.in_instruction;
          end
        end
        FULL: begin
          if (pop) begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_PC          = head_pc;
  assign bus.out_PC_plus4    = head_pc + ADDRESS_BITS'(4);
  assign bus.out_instruction = (state == EMPTY) ? DATA_WIDTH'(NOP_INSTR) : head_instr;
  assign bus.occupancy       = state;

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboarded bench for if_id_buffer: directed scenarios followed by randomized traffic.
module tb_if_id_buffer;
  import if_id_buffer_pkg::*;

  localparam int AB = 16;
  localparam int DW = 32;

  typedef struct {
    logic [AB-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_id_buffer_if #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW)) bus ();

  if_id_buffer #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  ent_t          exp_q[$];
  logic [AB-1:0] last_pc = '0;
  bit            started = 0;
  int            total = 0;
  int            bad = 0;

  bit   pend_push = 0;
  ent_t pend_ent;
  bit   prev_rst_low = 0;
  bit   prev_flush = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endfunction

  // One clock of stimulus; first folds the previous cycle's accepted push/flush/reset into the model
  task automatic cyc(input bit r, input bit v, input logic [AB-1:0] pc, input logic [DW-1:0] ins,
                     input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    if (prev_rst_low) begin
      exp_q.delete();
      last_pc = '0;
      started = 1;
    end else if (prev_flush) begin
      exp_q.delete();
    end else if (pend_push) begin
      exp_q.push_back(pend_ent);
    end
    rst_n              = r;
    bus.in_valid       = v;
    bus.in_PC          = pc;
    bus.in_instruction = ins;
    bus.out_ready      = ordy;
    bus.flush          = fl;
    pend_push    = r && !fl && v && (exp_q.size() < 2);
    pend_ent.pc    = pc;
    pend_ent.instr = ins;
    prev_rst_low = !r;
    prev_flush   = fl;
  endtask

  // Monitor: compares DUT against the model queue and consumes the head on a handshake
  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (started) begin
        n = exp_q.size();
        chk("occupancy", 32'(bus.occupancy), n);
        chk("out_valid", 32'(bus.out_valid), 32'(n != 0));
        chk("in_ready", 32'(bus.in_ready), 32'(rst_n && n < 2));
        if (n > 0) begin
          last_pc = exp_q[0].pc;
          chk("out_instruction", bus.out_instruction, exp_q[0].instr);
        end else begin
          chk("empty_nop", bus.out_instruction, NOP_INSTR);
        end
        chk("out_PC", 32'(bus.out_PC), 32'(last_pc));
        chk("out_PC_plus4", 32'(bus.out_PC_plus4), (32'(last_pc) + 32'd4) % 32'd65536);
        if (n > 0 && rst_n && !bus.flush && bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit            r, v, ordy, fl, hold;
    logic [AB-1:0] pc;
    logic [DW-1:0] ins;

    bus.in_valid = 0; bus.in_PC = '0; bus.in_instruction = '0;
    bus.out_ready = 0; bus.flush = 0;

    cyc(0, 0, 16'h0, 32'h0, 0, 0);
    cyc(0, 0, 16'h0, 32'h0, 0, 0);

    // Single push, then back-to-back fill with the third push held off
    cyc(1, 1, 16'h0000, 32'h0050_0093, 0, 0);
    cyc(1, 0, 16'h0000, 32'h0, 0, 0);
    cyc(1, 1, 16'h0004, 32'h0010_0113, 0, 0);
    cyc(1, 1, 16'h0008, 32'h0020_0193, 0, 0);
    cyc(1, 1, 16'h0008, 32'h0020_0193, 0, 0);
    cyc(1, 1, 16'h0008, 32'h0020_0193, 1, 0);
    cyc(1, 1, 16'h0008, 32'h0020_0193, 1, 0);
    cyc(1, 0, 16'h0000, 32'h0, 1, 0);
    cyc(1, 0, 16'h0000, 32'h0, 1, 0);

    // Streaming with the consumer always ready
    for (int a = 16'h10; a <= 16'h20; a += 4) cyc(1, 1, AB'(a), $urandom, 1, 0);
    cyc(1, 0, 16'h0, 32'h0, 1, 0);
    cyc(1, 0, 16'h0, 32'h0, 1, 0);

    // Flush a full queue while a new entry is offered
    cyc(1, 1, 16'h0030, 32'h1111_1111, 0, 0);
    cyc(1, 1, 16'h0034, 32'h2222_2222, 0, 0);
    cyc(1, 1, 16'h0040, 32'h3333_3333, 0, 1);
    cyc(1, 0, 16'h0, 32'h0, 0, 0);
    cyc(1, 0, 16'h0, 32'h0, 0, 0);

    // PC+4 wraparound
    cyc(1, 1, 16'hFFFC, 32'h4444_4444, 0, 0);
    cyc(1, 0, 16'h0, 32'h0, 0, 0);
    cyc(1, 0, 16'h0, 32'h0, 1, 0);
    cyc(1, 0, 16'h0, 32'h0, 0, 0);

    // Reset in ONE with push and pop both requested
    cyc(1, 1, 16'h0100, 32'h5555_5555, 0, 0);
    cyc(0, 1, 16'h0104, 32'h6666_6666, 1, 0);
    cyc(0, 1, 16'h0104, 32'h6666_6666, 1, 0);
    cyc(1, 0, 16'h0, 32'h0, 0, 0);
    cyc(1, 0, 16'h0, 32'h0, 0, 0);

    // Random traffic; a refused offer is held unchanged by the producer
    v = 0; pc = '0; ins = '0;
    for (int i = 0; i < 600; i++) begin
      hold = v && !pend_push && !prev_rst_low && !prev_flush;
      r    = ($urandom_range(0, 59) != 0);
      fl   = ($urandom_range(0, 11) == 0);
      ordy = ($urandom_range(0, 9) < 6);
      if (!hold) begin
        v   = ($urandom_range(0, 9) < 7);
        pc  = AB'($urandom_range(0, 16383) * 4);
        ins = $urandom;
      end
      cyc(r, v, pc, ins, ordy, fl);
    end
    cyc(1, 0, 16'h0, 32'h0, 1, 0);
    cyc(1, 0, 16'h0, 32'h0, 1, 0);
    cyc(1, 0, 16'h0, 32'h0, 1, 0);
    @(posedge clk);

    if (total < 12) begin
      bad++;
      $display("FAIL comparison_count: got %0d expected at least 12", total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter ADDRESS_BITS, default 16, width of PC fields.
REQ-002 Parameter DATA_WIDTH, default 32, instruction width.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous active-low reset; 0 = reset, sampled on rising clock edge.
REQ-005 in_valid  input  1  fetch side: PC/instruction pair offered.
REQ-006 in_ready  output  1  buffer can accept an entry this cycle.
REQ-007 in_PC  input  ADDRESS_BITS  PC of offered instruction.
REQ-008 in_instruction  input  DATA_WIDTH  instruction word fetched at in_PC.
REQ-009 flush  input  1  redirect (taken branch/jump); discard all held and incoming entries.
REQ-010 out_valid  output  1  decode side: head entry valid.
REQ-011 out_ready  input  1  decode consumes head entry this cycle.
REQ-012 out_PC  output  ADDRESS_BITS  PC of head entry.
REQ-013 out_PC_plus4  output  ADDRESS_BITS  out_PC + 4, modulo 2^ADDRESS_BITS.
REQ-014 out_instruction  output  DATA_WIDTH  head instruction word.
REQ-015 occupancy  output  2  entries held, 0..2.

Function
REQ-016 Storage SHALL be a 2-entry in-order queue; push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-017 State machine SHALL have states EMPTY, ONE, FULL; occupancy = 0/1/2 respectively, registered.
REQ-018 Transitions: EMPTY -push-> ONE; ONE -push&!pop-> FULL; ONE -pop&!push-> EMPTY; ONE -push&pop-> ONE; FULL -pop-> ONE; otherwise hold.
REQ-019 in_ready SHALL equal reset & (state != FULL), with no combinational path from out_ready or out_valid.
REQ-020 out_valid SHALL equal (state != EMPTY) and SHALL depend only on registered state.
REQ-021 Latency: entry pushed at edge N SHALL appear on out_* with out_valid=1 in the cycle after edge N when queue was EMPTY.
REQ-022 Order: entries SHALL leave in push order; simultaneous push and pop in ONE SHALL present the pushed entry as new head.
REQ-023 When EMPTY, out_instruction SHALL be DATA_WIDTH'h00000013 (NOP), out_PC and out_PC_plus4 SHALL hold last head values.
REQ-024 out_PC_plus4 SHALL wrap: out_PC = 2^ADDRESS_BITS-4 yields 0.
REQ-025 Head outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 flush=1 at an edge SHALL force EMPTY, discarding any push and pop in that cycle; out_valid=0 the following cycle.
REQ-027 flush SHALL take priority over push/pop; reset SHALL take priority over flush.
REQ-028 in_valid with in_ready=0 SHALL leave state and contents unchanged; upstream holds in_PC/in_instruction.

Reset
REQ-029 reset=0 at an edge SHALL force EMPTY: occupancy=0, out_valid=0, out_instruction=NOP, out_PC=0, out_PC_plus4=4.
REQ-030 in_ready SHALL be 0 whenever reset=0 and 1 in the first cycle after reset deasserts.
REQ-031 Reset asserted mid-operation SHALL discard all entries with no partial pop.

Structure
REQ-032 Shared package SHALL hold the NOP constant (32'h00000013), the EMPTY/ONE/FULL state encoding, and DATA_WIDTH default.
REQ-033 Block SHALL be a single module; no sub-module.

Verification
REQ-034 Reset then push PC=0x0000/instr=0x00500093 with out_ready=0 -> next cycle out_valid=1, out_PC=0x0000, out_PC_plus4=0x0004, occupancy=1.
REQ-035 Push 0x0000, 0x0004, 0x0008 back-to-back, out_ready=0 -> occupancy=2, in_ready=0, third push held; raise out_ready -> heads 0x0000 then 0x0004 then 0x0008 in order.
REQ-036 Steady stream PC 0x0010..0x0020 step 4 with out_ready=1 -> occupancy stays 1, one instruction out per cycle, no gaps after first.
REQ-037 FULL queue, flush=1 with in_valid=1 PC=0x0040 -> next cycle occupancy=0, out_valid=0, out_instruction=0x00000013, PC 0x0040 not stored.
REQ-038 Push PC=0xFFFC -> out_PC_plus4=0x0000.
REQ-039 Queue at ONE, reset=0 with push and pop asserted -> next cycle occupancy=0, out_valid=0, out_PC=0x0000, in_ready=0 while reset held.
